// File: rtl/dau_sym_tokenizer.sv
// Purpose : groups DAU digit symbols into BCD number tokens; ops/enter/clear/invalid become single tokens.
// Latency : a token appears one cycle after the accepting symbol handshake; a queued op/ENTER follows back-to-back.
// Backpressure: one-entry registered output plus one pending slot; o_sym_ready is low while either is occupied.
// Ports: i_clk/i_rst (sync, active-high); i_sym/i_sym_valid/o_sym_ready symbol input handshake;
//        o_tok_valid/i_tok_ready token handshake with o_tok_type, o_tok_value (right-aligned BCD), o_tok_len.

`ifndef DAU_SYM_WIDTH
`define DAU_SYM_WIDTH 5
`endif
`ifndef DAU_SYM_MUL
`define DAU_SYM_MUL 5'h1A
`endif
`ifndef DAU_SYM_DIV
`define DAU_SYM_DIV 5'h1E
`endif
`ifndef DAU_SYM_INVALID
`define DAU_SYM_INVALID 5'h1F
`endif

module dau_sym_tokenizer #(
  parameter  int MAX_DIGITS = 8,
  localparam int LEN_W      = $clog2(MAX_DIGITS + 1)
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic [`DAU_SYM_WIDTH-1:0] i_sym,
  input  logic                      i_sym_valid,
  output logic                      o_sym_ready,
  output logic                      o_tok_valid,
  input  logic                      i_tok_ready,
  output logic [2:0]                o_tok_type,
  output logic [4*MAX_DIGITS-1:0]   o_tok_value,
  output logic [LEN_W-1:0]          o_tok_len
);

  localparam int ACC_W = 4 * MAX_DIGITS;

  typedef enum logic [2:0] {
    TOK_NUM   = 3'd0,
    TOK_ADD   = 3'd1,
    TOK_SUB   = 3'd2,
    TOK_MUL   = 3'd3,
    TOK_DIV   = 3'd4,
    TOK_ENTER = 3'd5,
    TOK_CLEAR = 3'd6,
    TOK_ERROR = 3'd7
  } tok_type_e;

  typedef enum logic {ST_IDLE, ST_NUM} state_e;

  // ENTER shares the operator class: both terminate a number and queue behind it.
  typedef enum logic [2:0] {C_DIGIT, C_OP, C_SPACE, C_CLEAR, C_INVALID} sym_class_e;

  typedef struct packed {
    tok_type_e        typ;
    logic [ACC_W-1:0] value;
    logic [LEN_W-1:0] len;
  } tok_t;

  function automatic tok_t ctl_tok(input tok_type_e t);
    tok_t r;
    r.typ   = t;
    r.value = '0;
    r.len   = '0;
    return r;
  endfunction

  state_e           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             pend_vld_q, pend_vld_d;
  tok_type_e        pend_type_q, pend_type_d;
  logic             tok_vld_q, tok_vld_d;
  tok_t             tok_q, tok_d;

  sym_class_e       cls;
  tok_type_e        op_type;
  tok_t             num_tok;
  logic             accept;

  assign o_sym_ready = !tok_vld_q && !pend_vld_q;
  assign accept      = i_sym_valid && o_sym_ready;

  assign o_tok_valid = tok_vld_q;
  assign o_tok_type  = tok_q.typ;
  assign o_tok_value = tok_q.value;
  assign o_tok_len   = tok_q.len;

  // Symbol classification.
  always_comb begin
    cls     = C_INVALID;
    op_type = TOK_ERROR;
    if (i_sym[4] && (i_sym[3:0] <= 4'd9)) begin
      cls = C_DIGIT;
    end else begin
      case (i_sym)
        5'h1B:            begin cls = C_OP; op_type = TOK_ADD;   end
        5'h1D:            begin cls = C_OP; op_type = TOK_SUB;   end
        `DAU_SYM_MUL:     begin cls = C_OP; op_type = TOK_MUL;   end
        `DAU_SYM_DIV:     begin cls = C_OP; op_type = TOK_DIV;   end
        5'h0D:            begin cls = C_OP; op_type = TOK_ENTER; end
        5'h07:            cls = C_CLEAR;
        5'h02:            cls = C_SPACE;
        default:          cls = C_INVALID;
      endcase
    end
  end

  // A number that overflowed is reported as ERROR instead of a truncated value.
  always_comb begin
    if (ovf_q) begin
      num_tok = ctl_tok(TOK_ERROR);
    end else begin
      num_tok.typ   = TOK_NUM;
      num_tok.value = acc_q;
      num_tok.len   = cnt_q;
    end
  end

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    pend_vld_d  = pend_vld_q;
    pend_type_d = pend_type_q;
    tok_vld_d   = tok_vld_q;
    tok_d       = tok_q;

    // Output drain: a pending op/ENTER slides in with no bubble.
    if (tok_vld_q && i_tok_ready) begin
      if (pend_vld_q) begin
        tok_d      = ctl_tok(pend_type_q);
        pend_vld_d = 1'b0;
      end else begin
        tok_vld_d = 1'b0;
        tok_d     = '0;
      end
    end

    // accept implies the output register is empty, so no conflict with the drain above.
    if (accept) begin
      case (state_q)
        ST_IDLE: begin
          case (cls)
            C_DIGIT: begin
              acc_d   = ACC_W'(i_sym[3:0]);
              cnt_d   = LEN_W'(1);
              ovf_d   = 1'b0;
              state_d = ST_NUM;
            end
            C_SPACE: ;
            C_OP:    begin tok_vld_d = 1'b1; tok_d = ctl_tok(op_type);   end
            C_CLEAR: begin tok_vld_d = 1'b1; tok_d = ctl_tok(TOK_CLEAR); end
            default: begin tok_vld_d = 1'b1; tok_d = ctl_tok(TOK_ERROR); end
          endcase
        end
        ST_NUM: begin
          if (cls == C_DIGIT) begin
            if (cnt_q < LEN_W'(MAX_DIGITS)) begin
              acc_d = (acc_q << 4) | ACC_W'(i_sym[3:0]);
              cnt_d = cnt_q + LEN_W'(1);
            end else begin
              ovf_d = 1'b1;
            end
          end else begin
            state_d   = ST_IDLE;
            acc_d     = '0;
            cnt_d     = '0;
            ovf_d     = 1'b0;
            tok_vld_d = 1'b1;
            case (cls)
              C_SPACE: tok_d = num_tok;
              C_OP: begin
                tok_d       = num_tok;
                pend_vld_d  = 1'b1;
                pend_type_d = op_type;
              end
              C_CLEAR: tok_d = ctl_tok(TOK_CLEAR);
              default: tok_d = ctl_tok(TOK_ERROR);
            endcase
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= ST_IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      pend_vld_q  <= 1'b0;
      pend_type_q <= TOK_NUM;
      tok_vld_q   <= 1'b0;
      tok_q       <= '0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      pend_vld_q  <= pend_vld_d;
      pend_type_q <= pend_type_d;
      tok_vld_q   <= tok_vld_d;
      tok_q       <= tok_d;
    end
  end

endmodule

// File: tb/tb_dau_sym_tokenizer.sv
// Purpose : self-checking bench for dau_sym_tokenizer; directed cases plus randomized symbol streams.
// Latency : expected tokens come from a digit-list reference model updated on each accepted symbol.
// Backpressure: i_tok_ready is randomized or forced; stalled tokens must hold stable.

`ifndef DAU_SYM_WIDTH
`define DAU_SYM_WIDTH 5
`endif
`ifndef DAU_SYM_MUL
`define DAU_SYM_MUL 5'h1A
`endif
`ifndef DAU_SYM_DIV
`define DAU_SYM_DIV 5'h1E
`endif
`ifndef DAU_SYM_INVALID
`define DAU_SYM_INVALID 5'h1F
`endif

module tb_dau_sym_tokenizer;

  localparam int MAXD  = 8;
  localparam int LEN_W = $clog2(MAXD + 1);

  logic                      i_clk = 1'b0;
  logic                      i_rst = 1'b1;
  logic [`DAU_SYM_WIDTH-1:0] i_sym = '0;
  logic                      i_sym_valid = 1'b0;
  logic                      o_sym_ready;
  logic                      o_tok_valid;
  logic                      i_tok_ready = 1'b0;
  logic [2:0]                o_tok_type;
  logic [4*MAXD-1:0]         o_tok_value;
  logic [LEN_W-1:0]          o_tok_len;

  dau_sym_tokenizer #(.MAX_DIGITS(MAXD)) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_sym       (i_sym),
    .i_sym_valid (i_sym_valid),
    .o_sym_ready (o_sym_ready),
    .o_tok_valid (o_tok_valid),
    .i_tok_ready (i_tok_ready),
    .o_tok_type  (o_tok_type),
    .o_tok_value (o_tok_value),
    .o_tok_len   (o_tok_len)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    int     typ;
    longint value;
    int     len;
  } etok_t;

  etok_t  exp_q[$];
  etok_t  e_cur;
  etok_t  held;
  bit     stalled = 1'b0;
  int     n_tests = 0;
  int     n_fail  = 0;
  int     rdy_mode = 2;   // 0 random, 1 forced low, 2 forced high

  // Reference model state: the digits of the number currently being typed.
  bit     m_in_num = 1'b0;
  bit     m_ovf    = 1'b0;
  int     m_digits[$];

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic void m_emit(input int t, input longint v, input int l);
    etok_t x;
    x.typ = t; x.value = v; x.len = l;
    exp_q.push_back(x);
  endfunction

  function automatic void m_flush_num();
    longint v = 0;
    if (m_ovf) begin
      m_emit(7, 0, 0);
    end else begin
      foreach (m_digits[i]) v = v * 16 + longint'(m_digits[i]);
      m_emit(0, v, m_digits.size());
    end
    m_in_num = 1'b0;
  endfunction

  function automatic void m_accept(input logic [4:0] s);
    int op = -1;
    case (s)
      5'h1B:        op = 1;
      5'h1D:        op = 2;
      `DAU_SYM_MUL: op = 3;
      `DAU_SYM_DIV: op = 4;
      5'h0D:        op = 5;
      default:      op = -1;
    endcase
    if (s >= 5'h10 && s <= 5'h19) begin
      if (!m_in_num) begin
        m_digits.delete();
        m_digits.push_back(int'(s) - 16);
        m_in_num = 1'b1;
        m_ovf    = 1'b0;
      end else if (m_digits.size() < MAXD) begin
        m_digits.push_back(int'(s) - 16);
      end else begin
        m_ovf = 1'b1;
      end
    end else if (s == 5'h02) begin
      if (m_in_num) m_flush_num();
    end else if (op >= 0) begin
      if (m_in_num) m_flush_num();
      m_emit(op, 0, 0);
    end else if (s == 5'h07) begin
      m_in_num = 1'b0;
      m_emit(6, 0, 0);
    end else begin
      m_in_num = 1'b0;
      m_emit(7, 0, 0);
    end
  endfunction

  // Ready driver.
  always @(posedge i_clk) begin
    #1;
    case (rdy_mode)
      1:       i_tok_ready = 1'b0;
      2:       i_tok_ready = 1'b1;
      default: i_tok_ready = ($urandom_range(0, 3) != 0);
    endcase
  end

  // Monitor: sampled on the falling edge, away from the active edge.
  always @(negedge i_clk) begin
    if (i_rst) begin
      exp_q.delete();
      m_digits.delete();
      m_in_num = 1'b0;
      m_ovf    = 1'b0;
      stalled  = 1'b0;
    end else begin
      if (stalled) begin
        chk("hold_vld",   o_tok_valid, 1);
        chk("hold_type",  o_tok_type,  held.typ);
        chk("hold_value", o_tok_value, held.value);
        chk("hold_len",   o_tok_len,   held.len);
      end
      if (o_tok_valid) chk("sym_rdy_while_tok", o_sym_ready, 0);
      if (o_tok_valid && i_tok_ready) begin
        if (exp_q.size() == 0) begin
          chk("extra_tok", o_tok_valid, 0);
        end else begin
          e_cur = exp_q.pop_front();
          chk("tok_type",  o_tok_type,  e_cur.typ);
          chk("tok_value", o_tok_value, e_cur.value);
          chk("tok_len",   o_tok_len,   e_cur.len);
        end
      end
      stalled    = o_tok_valid && !i_tok_ready;
      held.typ   = int'(o_tok_type);
      held.value = longint'(o_tok_value);
      held.len   = int'(o_tok_len);
      if (i_sym_valid && o_sym_ready) m_accept(i_sym);
    end
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [4:0] s);
    bit ok = 1'b0;
    i_sym       = s;
    i_sym_valid = 1'b1;
    for (int n = 0; n < 100; n++) begin
      @(negedge i_clk);
      if (o_sym_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("send_timeout", o_sym_ready, 1);
    tick();
    i_sym_valid = 1'b0;
    i_sym       = '0;
  endtask

  task automatic drain(input string tag);
    rdy_mode = (rdy_mode == 1) ? 2 : rdy_mode;
    for (int n = 0; n < 60; n++) begin
      @(negedge i_clk);
      if (exp_q.size() == 0 && !o_tok_valid) break;
    end
    chk(tag, exp_q.size(), 0);
    tick();
  endtask

  task automatic pulse_reset();
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
  endtask

  logic [4:0] other_syms [10];

  initial begin
    int lo;
    logic [4:0] s;
    other_syms = '{5'h02, 5'h1B, 5'h1D, `DAU_SYM_MUL, `DAU_SYM_DIV,
                   5'h0D, 5'h07, 5'h1C, `DAU_SYM_INVALID, 5'h00};

    // Reset state.
    repeat (3) tick();
    i_rst = 1'b0;
    @(negedge i_clk);
    chk("rst_tok_valid", o_tok_valid, 0);
    chk("rst_sym_ready", o_sym_ready, 1);
    chk("rst_tok_type",  o_tok_type,  0);
    chk("rst_tok_value", o_tok_value, 0);
    chk("rst_tok_len",   o_tok_len,   0);
    tick();

    // "123" ENTER with the sink always ready: input stalls exactly two cycles.
    rdy_mode = 2;
    send(5'h11); send(5'h12); send(5'h13); send(5'h0D);
    lo = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge i_clk);
      if (o_sym_ready) break;
      lo++;
    end
    chk("enter_rdy_low_cycles", lo, 2);
    tick();
    drain("drain_123_enter");

    // "12 3+": a space in IDLE produces nothing.
    send(5'h11); send(5'h12); send(5'h02); send(5'h02); send(5'h13); send(5'h1B);
    drain("drain_12_3_add");

    // Overflow: nine digits then space is one ERROR; the next number is clean.
    rdy_mode = 0;
    repeat (9) send(5'h19);
    send(5'h02); send(5'h15); send(5'h0D);
    drain("drain_overflow");

    // A number terminated by CLEAR or an invalid code is discarded.
    send(5'h14); send(5'h07);
    send(5'h14); send(5'h1C);
    send(5'h14); send(`DAU_SYM_INVALID);
    send(5'h10); send(5'h10); send(5'h17); send(5'h02);
    drain("drain_discard");

    // Backpressure: NUM 9 held for 5 cycles, then NUM and MUL back-to-back.
    rdy_mode = 1;
    send(5'h19); send(`DAU_SYM_MUL);
    for (int n = 0; n < 5; n++) begin
      @(negedge i_clk);
      chk("bp_vld",   o_tok_valid, 1);
      chk("bp_type",  o_tok_type,  0);
      chk("bp_value", o_tok_value, 9);
      chk("bp_len",   o_tok_len,   1);
      chk("bp_sym_rdy", o_sym_ready, 0);
    end
    rdy_mode = 2;
    @(negedge i_clk);
    chk("bp_rel_num_vld",  o_tok_valid, 1);
    chk("bp_rel_num_type", o_tok_type,  0);
    @(negedge i_clk);
    chk("bp_rel_mul_vld",  o_tok_valid, 1);
    chk("bp_rel_mul_type", o_tok_type,  3);
    tick();
    drain("drain_backpressure");

    // Reset mid-number (three digits in).
    rdy_mode = 0;
    send(5'h11); send(5'h12); send(5'h13);
    pulse_reset();
    @(negedge i_clk);
    chk("rst_num_tok_valid", o_tok_valid, 0);
    chk("rst_num_sym_ready", o_sym_ready, 1);
    tick();
    send(5'h17); send(5'h0D);
    drain("drain_after_rst_num");

    // Reset with a token out and one pending.
    rdy_mode = 1;
    send(5'h14); send(5'h1B);
    tick();
    pulse_reset();
    rdy_mode = 0;
    @(negedge i_clk);
    chk("rst_pend_tok_valid", o_tok_valid, 0);
    chk("rst_pend_sym_ready", o_sym_ready, 1);
    chk("rst_pend_tok_type",  o_tok_type,  0);
    chk("rst_pend_tok_value", o_tok_value, 0);
    tick();
    send(5'h17); send(5'h0D);
    drain("drain_after_rst_pend");

    // Randomized streams with random sink stalls and rare resets.
    rdy_mode = 0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 9) < 6) s = 5'(5'h10 + $urandom_range(0, 9));
      else if ($urandom_range(0, 9) == 0) s = 5'($urandom);
      else s = other_syms[$urandom_range(0, 9)];
      send(s);
      if ($urandom_range(0, 3) == 0) tick();
      if ($urandom_range(0, 149) == 0) pulse_reset();
    end
    send(5'h02);
    drain("drain_random");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #600000;
    n_fail++;
    $display("FAIL watchdog: simulation did not complete in time");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/dau_sym_tokenizer.md
Name: dau_sym_tokenizer

Overview:
Sits directly downstream of the ASCII-to-DAU-symbol decoder. It consumes one 5-bit DAU symbol per handshake and groups decimal digit symbols into BCD number tokens. It turns operator, enter, clear and invalid symbols into single tokens for the RPN evaluation stage. Output is a one-entry registered token stream with valid/ready flow control.

Parameters:
MAX_DIGITS, 8, maximum BCD digits in one number token; localparam LEN_W = $clog2(MAX_DIGITS+1)

Ports:
i_clk  input  1  system clock
i_rst  input  1  synchronous, active-high reset
i_sym  input  `DAU_SYM_WIDTH  DAU symbol from decoder
i_sym_valid  input  1  i_sym valid
o_sym_ready  output  1  block accepts i_sym this cycle
o_tok_valid  output  1  token present
i_tok_ready  input  1  downstream accepts token
o_tok_type  output  3  0 NUM, 1 ADD, 2 SUB, 3 MUL, 4 DIV, 5 ENTER, 6 CLEAR, 7 ERROR
o_tok_value  output  4*MAX_DIGITS  BCD number, right-aligned, last digit in [3:0]; 0 for non-NUM
o_tok_len  output  LEN_W  digit count 1..MAX_DIGITS for NUM; 0 otherwise

Behaviour:
- Clock i_clk; reset i_rst is synchronous and active-high. No other clock or reset.
- Symbol classes:
  - digits 5'h10..5'h19 carry value sym[3:0]
  - 5'h1B ADD; 5'h1D SUB; `DAU_SYM_MUL MUL; `DAU_SYM_DIV DIV
  - 5'h0D ENTER; 5'h07 CLEAR; 5'h02 SPACE
  - 5'h1C, `DAU_SYM_INVALID and every other code are INVALID
- Symbol handshake: accept when i_sym_valid && o_sym_ready. o_sym_ready = !o_tok_valid && !pend_valid, driven from registers only. It reads 1 after reset.
- Token handshake: o_tok_valid, type, value and len are held stable until i_tok_ready is seen high with o_tok_valid. A token appears the cycle after the accepting symbol handshake.
- Internal state: IDLE and NUM; accumulator acc (4*MAX_DIGITS bits); count (LEN_W bits); sticky ovf; pending-token register (pend_valid, pend_type).
- IDLE transitions:
  - digit: acc = digit, count = 1, ovf = 0, go to NUM; no token
  - SPACE: consumed, no token
  - op/ENTER/CLEAR/INVALID: emit matching token (INVALID emits ERROR)
- NUM transitions:
  - digit with count < MAX_DIGITS: acc = {acc << 4} | digit, count++
  - digit with count == MAX_DIGITS: set ovf, acc and count unchanged
  - SPACE: emit NUM (or ERROR if ovf), go to IDLE
  - op or ENTER: emit NUM (or ERROR if ovf), load pend with the op/ENTER token, go to IDLE
  - CLEAR: discard the number, emit CLEAR only, go to IDLE
  - INVALID: discard the number, emit ERROR only, go to IDLE
- Pending token: on the output handshake, if pend_valid then pend moves to the output the next cycle (o_tok_valid stays high, no bubble required) and pend_valid clears. Tokens are never reordered.
- Leading zeros are kept and counted in len ("007" gives value 0x007, len 3).
- Reset at any point, including mid-number or with a pending token: state IDLE, acc 0, count 0, ovf 0, pend_valid 0. All outputs 0 except o_sym_ready = 1. No partial token is emitted.
- A token stalled by i_tok_ready low never drops or duplicates; o_sym_ready stays low throughout.

Test Plan:
- Reset, then symbols 5'h11, 5'h12, 5'h13, 5'h0D with i_tok_ready = 1 -> NUM value 0x123 len 3, then ENTER value 0 len 0. o_sym_ready low for exactly the cycles pend/output are occupied.
- "12 3+" (5'h11, 5'h12, 5'h02, 5'h13, 5'h1B) -> NUM 0x12 len 2, NUM 0x3 len 1, ADD. The space in IDLE emits nothing.
- MAX_DIGITS = 8, nine digit symbols 5'h19 then 5'h02 -> a single ERROR token. A following "5" + ENTER -> NUM 0x5 len 1, ENTER (ovf cleared).
- "4", then 5'h07 -> CLEAR only, no NUM. "4", then 5'h1C -> ERROR only. "4", then `DAU_SYM_INVALID -> ERROR only.
- Backpressure: "9*" with i_tok_ready low for 5 cycles -> NUM 0x9 held stable all 5 cycles, o_sym_ready = 0. Release -> NUM, then MUL on consecutive handshakes.
- Assert i_rst while in NUM with count 3, or with pend_valid = 1 -> next cycle o_tok_valid = 0, o_sym_ready = 1. A following "7" + 5'h0D yields NUM 0x7 len 1, ENTER.
